// File: rtl/codeconvert_pkg.sv
// Shared mode encodings and code-range bounds for the nibble code converter.
package codeconvert_pkg;

    typedef enum logic [1:0] {
        MODE_B2G     = 2'b00,
        MODE_G2B     = 2'b01,
        MODE_BCD2XS3 = 2'b10,
        MODE_XS32BCD = 2'b11
    } mode_t;

    localparam logic [3:0] XS3_OFFSET = 4'd3;

    localparam logic [3:0] BCD_MIN = 4'd0;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] XS3_MIN = 4'd3;
    localparam logic [3:0] XS3_MAX = 4'd12;

endpackage

// File: rtl/codeconvert_if.sv
// Conversion request/result bundle between a requester and the converter.
interface codeconvert_if;

    logic       in_valid;
    logic [1:0] mode;
    logic       a, b, c, d;
    logic       e, f, g, h;
    logic       out_valid;
    logic       err;

    modport master (
        output in_valid, mode, a, b, c, d,
        input  e, f, g, h, out_valid, err
    );

    modport slave (
        input  in_valid, mode, a, b, c, d,
        output e, f, g, h, out_valid, err
    );

endinterface

// File: rtl/codeconvert_core.sv
// Combinational nibble converter: Gray/binary and BCD/XS3 in both directions.
module codeconvert_core
    import codeconvert_pkg::*;
#(
    parameter logic [3:0] INVALID_CODE = 4'b1111
) (
    input  logic [3:0] code_in,
    input  logic [1:0] mode,
    output logic [3:0] code_out,
    output logic       invalid
);

    always_comb begin
        code_out = code_in;
        invalid  = 1'b0;
        case (mode_t'(mode))
            MODE_B2G: begin
                code_out = code_in ^ {1'b0, code_in[3:1]};
            end
            MODE_G2B: begin
                // each binary bit is the running xor of the Gray bits from the MSB down
                code_out[3] = code_in[3];
                code_out[2] = code_in[3] ^ code_in[2];
                code_out[1] = code_in[3] ^ code_in[2] ^ code_in[1];
                code_out[0] = code_in[3] ^ code_in[2] ^ code_in[1] ^ code_in[0];
            end
            MODE_BCD2XS3: begin
                if (code_in >= BCD_MIN && code_in <= BCD_MAX) begin
                    code_out = code_in + XS3_OFFSET;
                end else begin
                    code_out = INVALID_CODE;
                    invalid  = 1'b1;
                end
            end
            MODE_XS32BCD: begin
                if (code_in >= XS3_MIN && code_in <= XS3_MAX) begin
                    code_out = code_in - XS3_OFFSET;
                end else begin
                    code_out = INVALID_CODE;
                    invalid  = 1'b1;
                end
            end
            default: begin
                code_out = code_in;
                invalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/codeconvert.sv
// Code converter top: one register stage of result, valid and error flag.
module codeconvert
    import codeconvert_pkg::*;
#(
    parameter logic [3:0] INVALID_CODE = 4'b1111
) (
    input  logic         clk,
    input  logic         rst,
    codeconvert_if.slave bus
);

    logic [3:0] code_next;
    logic       invalid_next;
    logic [3:0] code_q;
    logic       out_valid_q;
    logic       err_q;

    codeconvert_core #(
        .INVALID_CODE (INVALID_CODE)
    ) u_core (
        .code_in  ({bus.a, bus.b, bus.c, bus.d}),
        .mode     (bus.mode),
        .code_out (code_next),
        .invalid  (invalid_next)
    );

    // idle cycles keep the last result visible but drop valid and error
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q      <= 4'b0000;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (bus.in_valid) begin
            code_q      <= code_next;
            out_valid_q <= 1'b1;
            err_q       <= invalid_next;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end
    end

    assign bus.e         = code_q[3];
    assign bus.f         = code_q[2];
    assign bus.g         = code_q[1];
    assign bus.h         = code_q[0];
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_codeconvert.sv
// Randomised and directed bench for codeconvert against a behavioural code model.
module tb_codeconvert;

    localparam logic [3:0] INV = 4'b1111;

    logic clk;
    logic rst;

    codeconvert_if bus ();

    codeconvert #(.INVALID_CODE(INV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural expectation: {err, nibble}
    function automatic logic [4:0] ref_conv(input logic [1:0] m, input logic [3:0] n);
        logic [3:0] r;
        int v;
        v = int'(n);
        r = 4'd0;
        case (m)
            2'd0: return {1'b0, n ^ (n >> 1)};
            2'd1: begin
                for (int i = 0; i < 4; i++) r[i] = ^(n >> i);
                return {1'b0, r};
            end
            2'd2: begin
                if (v <= 9) return {1'b0, 4'(v + 3)};
                return {1'b1, INV};
            end
            default: begin
                if (v >= 3 && v <= 12) return {1'b0, 4'(v - 3)};
                return {1'b1, INV};
            end
        endcase
    endfunction

    logic [3:0] exp_nib;
    logic       exp_ov;
    logic       exp_err;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_nib <= 4'd0;
            exp_ov  <= 1'b0;
            exp_err <= 1'b0;
            chk_en  <= 1'b1;
        end else if (bus.in_valid) begin
            {exp_err, exp_nib} <= ref_conv(bus.mode, {bus.a, bus.b, bus.c, bus.d});
            exp_ov <= 1'b1;
        end else begin
            exp_ov  <= 1'b0;
            exp_err <= 1'b0;
        end
    end

    function automatic logic [3:0] dut_nib();
        return {bus.e, bus.f, bus.g, bus.h};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({dut_nib(), bus.out_valid, bus.err} !== {exp_nib, exp_ov, exp_err}) begin
                bad++;
                $display("FAIL model t=%0t: got nib=%b ov=%b err=%b, want nib=%b ov=%b err=%b",
                         $time, dut_nib(), bus.out_valid, bus.err, exp_nib, exp_ov, exp_err);
            end
            total++;
            if (!bus.out_valid && bus.err !== 1'b0) begin
                bad++;
                $display("FAIL err_without_valid t=%0t: err=%b, want 0", $time, bus.err);
            end
        end
    end

    task automatic lit(input string name, input logic [3:0] nib, input logic ov, input logic er);
        total++;
        if ({dut_nib(), bus.out_valid, bus.err} !== {nib, ov, er}) begin
            bad++;
            $display("FAIL %s: got nib=%b ov=%b err=%b, want nib=%b ov=%b err=%b",
                     name, dut_nib(), bus.out_valid, bus.err, nib, ov, er);
        end
    endtask

    // drive one cycle of inputs, return #1 after the capturing edge
    task automatic step(input logic v, input logic [1:0] m, input logic [3:0] n);
        bus.in_valid = v;
        bus.mode     = m;
        {bus.a, bus.b, bus.c, bus.d} = n;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_out [16];
    logic [3:0] held;

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.mode     = 2'b00;
        {bus.a, bus.b, bus.c, bus.d} = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        lit("reset_discard", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 2'b00, 4'b1111);
        lit("reset_state", 4'b0000, 1'b0, 1'b0);

        step(1'b1, 2'b00, 4'b0110);
        lit("first_b2g_0110", 4'b0101, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'b00, 4'(i));
            gray_out[i] = dut_nib();
        end
        lit("b2g_1111", 4'b1000, 1'b1, 1'b0);

        step(1'b1, 2'b01, 4'b1000);
        lit("g2b_1000", 4'b1111, 1'b1, 1'b0);
        step(1'b1, 2'b01, 4'b0101);
        lit("g2b_0101", 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'b01, gray_out[i]);
            lit($sformatf("roundtrip_%0d", i), 4'(i), 1'b1, 1'b0);
        end

        step(1'b1, 2'b10, 4'b1001);
        lit("bcd_1001", 4'b1100, 1'b1, 1'b0);
        step(1'b1, 2'b10, 4'b1010);
        lit("bcd_1010", 4'b1111, 1'b1, 1'b1);
        step(1'b1, 2'b11, 4'b0011);
        lit("xs3_0011", 4'b0000, 1'b1, 1'b0);
        step(1'b1, 2'b11, 4'b1100);
        lit("xs3_1100", 4'b1001, 1'b1, 1'b0);
        step(1'b1, 2'b11, 4'b0010);
        lit("xs3_0010", 4'b1111, 1'b1, 1'b1);
        step(1'b1, 2'b11, 4'b1101);
        lit("xs3_1101", 4'b1111, 1'b1, 1'b1);

        step(1'b1, 2'b00, 4'b0011);
        lit("toggle_b2g", 4'b0010, 1'b1, 1'b0);
        step(1'b1, 2'b10, 4'b0011);
        lit("toggle_bcd", 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, (i % 2 == 0) ? 2'b00 : 2'b10, 4'($urandom_range(0, 15)));
        end
        held = dut_nib();
        step(1'b0, 2'b11, 4'b0000);
        lit("idle_hold", held, 1'b0, 1'b0);
        step(1'b0, 2'b10, 4'b1111);
        lit("idle_hold2", held, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        step(1'b0, 2'b00, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codeconvert.md
CODECONVERT -- requirements
Module: codeconvert

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 The block SHALL provide parameter INVALID_CODE, default 4'b1111, which is the output nibble driven for an invalid input code.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  marks a, b, c, d and mode as valid for conversion this cycle.
REQ-006 mode  input  2  conversion select: 00 bin->Gray, 01 Gray->bin, 10 BCD->XS3, 11 XS3->BCD.
REQ-007 a, b, c, d  input  1 each  input nibble; a is the MSB and d is the LSB.
REQ-008 e, f, g, h  output  1 each  converted nibble; e is the MSB and h is the LSB.
REQ-009 out_valid  output  1  e..h hold a new result this cycle.
REQ-010 err  output  1  the result came from an invalid BCD or XS3 input.

Function
REQ-011 All outputs SHALL be registered, with a latency of exactly 1 clk from an in_valid=1 sample to out_valid=1 with the result.
REQ-012 mode=00 SHALL compute e=a, f=a^b, g=b^c, h=c^d.
REQ-013 mode=01 SHALL compute e=a, f=a^b, g=a^b^c, h=a^b^c^d.
REQ-014 mode=10 SHALL output {e,f,g,h} = {a,b,c,d}+3 for inputs 0..9, as 4-bit arithmetic with no overflow.
REQ-015 mode=10 with inputs 10..15 SHALL output INVALID_CODE with err=1.
REQ-016 mode=11 SHALL output {a,b,c,d}-3 for inputs 3..12.
REQ-017 mode=11 with inputs 0..2 or 13..15 SHALL output INVALID_CODE with err=1.
REQ-018 Modes 00 and 01 SHALL never assert err, since all 16 codes are valid.
REQ-019 A cycle with in_valid=0 SHALL hold e..h at their previous value and clear out_valid and err on the next edge.
REQ-020 mode SHALL be sampled together with the data on the same edge, so a mode change between back-to-back valid inputs applies only to the input sampled with it, with no bubble.
REQ-021 err SHALL equal 0 whenever out_valid=0.
REQ-022 Bin->Gray followed by Gray->bin SHALL return the original nibble for all 16 values.

Reset
REQ-023 While rst=1 at a clk edge, e, f, g, h, out_valid and err SHALL all become 0.
REQ-024 rst SHALL take priority over in_valid, so an input presented in the reset cycle is discarded.
REQ-025 The first valid result after reset release SHALL appear 1 clk after the first in_valid=1 sample.

Structure
REQ-026 Package codeconvert_pkg SHALL hold the mode encodings (MODE_B2G, MODE_G2B, MODE_BCD2XS3, MODE_XS32BCD), XS3_OFFSET=3 and the BCD and XS3 valid-range bounds.
REQ-027 A purely combinational sub-module codeconvert_core SHALL take the nibble and mode and produce the next code and an invalid flag.
REQ-028 The top level SHALL contain only the output and flag registers around codeconvert_core.

Verification
REQ-029 Reset with rst=1 for 2 clks, then release -> e..h=0000, out_valid=0, err=0.
REQ-030 mode=00, sweep inputs 0..15 with in_valid=1 each clk -> Gray codes; for example 0110 gives 0101, 1111 gives 1000; out_valid=1 one clk later.
REQ-031 mode=01 with input 1000 -> 1111, and with input 0101 -> 0110; also feed all Gray outputs back -> the original values.
REQ-032 mode=10 with input 1001 -> 1100 and err=0; with input 1010 -> 1111 and err=1.
REQ-033 mode=11 with input 0011 -> 0000, with input 1100 -> 1001, and with input 0010 -> 1111 and err=1.
REQ-034 Back-to-back inputs with mode toggling 00/10 each clk, then in_valid=0 -> each result matches its own mode, then out_valid=0 and e..h are held.
